// File: rtl/dma_rom_copier.sv
// dma_rom_copier: block-copy engine from the ROM controller into main memory.
// The processor programs source, destination and length through memory-mapped
// register writes; a length write with a non-zero value starts the copy. While
// copying, the processor is stalled (proc_en=0) and each ROM word is fetched
// with a load_rom/ready handshake and then written to memory with dst_write.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   en, write         register select and write strobe from the processor side
//   wr_mode           register index: 0 src[15:0], 1 src[22:16], 2 dst, 3 length+start
//   ctrl_data         processor write data
//   src_addr          ROM word address, valid while load_rom=1
//   load_rom          one-cycle ROM read request
//   src_data, ready   ROM read data and its data-valid pulse
//   dst_addr          memory write address
//   dst_data          memory write data
//   dst_write         one-cycle memory write strobe
//   proc_en           0 while a copy is active
//   busy              1 whenever the engine is not idle
//   err               sticky timeout flag, cleared by the next start
module dma_rom_copier #(
    parameter int unsigned SRC_W   = 23,
    parameter int unsigned DST_W   = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              write,
    input  logic [1:0]        wr_mode,
    input  logic [DATA_W-1:0] ctrl_data,
    output logic [SRC_W-1:0]  src_addr,
    output logic              load_rom,
    input  logic [DATA_W-1:0] src_data,
    input  logic              ready,
    output logic [DST_W-1:0]  dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_write,
    output logic              proc_en,
    output logic              busy,
    output logic              err
);

    localparam int unsigned TMO_W  = 8;
    localparam int unsigned SRC_LO = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [SRC_W-1:0]  src, src_n;
    logic [DST_W-1:0]  dst, dst_n;
    logic [DATA_W-1:0] len, len_n;
    logic [TMO_W-1:0]  tmo, tmo_n;
    logic              err_n;

    logic [SRC_W-1:0]  src_addr_n;
    logic              load_rom_n;
    logic [DST_W-1:0]  dst_addr_n;
    logic [DATA_W-1:0] dst_data_n;
    logic              dst_write_n;
    logic              proc_en_n;
    logic              busy_n;

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            tmo       <= '0;
            err       <= 1'b0;
            src_addr  <= '0;
            load_rom  <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= '0;
            dst_write <= 1'b0;
            proc_en   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            src       <= src_n;
            dst       <= dst_n;
            len       <= len_n;
            tmo       <= tmo_n;
            err       <= err_n;
            src_addr  <= src_addr_n;
            load_rom  <= load_rom_n;
            dst_addr  <= dst_addr_n;
            dst_data  <= dst_data_n;
            dst_write <= dst_write_n;
            proc_en   <= proc_en_n;
            busy      <= busy_n;
        end
    end

    // Next-state, register programming and next output values.
    always_comb begin
        state_n     = state;
        src_n       = src;
        dst_n       = dst;
        len_n       = len;
        tmo_n       = tmo;
        err_n       = err;
        src_addr_n  = '0;
        load_rom_n  = 1'b0;
        dst_addr_n  = '0;
        dst_data_n  = '0;
        dst_write_n = 1'b0;

        case (state)
            IDLE: begin
                if (en && write) begin
                    case (wr_mode)
                        2'd0: src_n = {src[SRC_W-1:SRC_LO], ctrl_data[SRC_LO-1:0]};
                        2'd1: src_n = {ctrl_data[SRC_W-SRC_LO-1:0], src[SRC_LO-1:0]};
                        2'd2: dst_n = DST_W'(ctrl_data);
                        2'd3: begin
                            // A zero length is dropped entirely.
                            if (ctrl_data != '0) begin
                                len_n   = ctrl_data;
                                err_n   = 1'b0;
                                state_n = REQ;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            REQ: begin
                tmo_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (ready) begin
                    // The write-data register doubles as the latch for the ROM word.
                    dst_write_n = 1'b1;
                    dst_addr_n  = dst;
                    dst_data_n  = src_data;
                    state_n     = WRITE;
                end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                    // TIMEOUT wait cycles without ready: abandon the copy.
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo + TMO_W'(1);
                end
            end
            WRITE: begin
                src_n   = src + SRC_W'(1);
                dst_n   = dst + DST_W'(1);
                len_n   = len - DATA_W'(1);
                state_n = (len != DATA_W'(1)) ? REQ : IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Request is registered on REQ entry so it is high for the whole REQ cycle.
        if (state_n == REQ) begin
            load_rom_n = 1'b1;
            src_addr_n = src_n;
        end

        busy_n    = (state_n != IDLE);
        proc_en_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_dma_rom_copier.sv
// Self-checking bench for dma_rom_copier: a behavioural ROM responder with
// programmable latency and stray ready pulses, a write monitor, and a model
// that predicts written addresses/data and busy duration per copy.
module tb_dma_rom_copier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  wr_mode = 2'd0;
    logic [15:0] ctrl_data = 16'd0;
    logic [22:0] src_addr;
    logic        load_rom;
    logic [15:0] src_data = 16'd0;
    logic        ready = 1'b0;
    logic [15:0] dst_addr;
    logic [15:0] dst_data;
    logic        dst_write;
    logic        proc_en;
    logic        busy;
    logic        err;

    dma_rom_copier dut (
        .clk(clk), .rst(rst), .en(en), .write(write), .wr_mode(wr_mode),
        .ctrl_data(ctrl_data), .src_addr(src_addr), .load_rom(load_rom),
        .src_data(src_data), .ready(ready), .dst_addr(dst_addr),
        .dst_data(dst_data), .dst_write(dst_write), .proc_en(proc_en),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] rom_word(input logic [22:0] a);
        return a[15:0] ^ {a[22:16], a[22:16], 2'b01} ^ 16'h5a3c;
    endfunction

    // ROM responder
    int          lat_q[$];
    bit          withhold = 1'b0;
    bit          noise = 1'b0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [22:0] raddr = '0;

    always begin
        @(posedge clk);
        #1;
        ready    = 1'b0;
        src_data = 16'($urandom);
        if (rst) begin
            pending = 1'b0;
        end else if (pending) begin
            cnt--;
            if (cnt == 0) begin
                ready    = 1'b1;
                src_data = rom_word(raddr);
                pending  = 1'b0;
            end
        end else if (load_rom) begin
            raddr = src_addr;
            if (!withhold) begin
                pending = 1'b1;
                cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            end
            if (noise && $urandom_range(1, 0) == 1) ready = 1'b1;
        end else if (dst_write && noise && $urandom_range(1, 0) == 1) begin
            ready = 1'b1;
        end
    end

    // Write / activity monitor
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t wq[$];
    int  busy_cyc = 0;
    int  pen_low = 0;
    int  loads = 0;
    int  excl_viol = 0;

    always @(negedge clk) begin
        if (dst_write) wq.push_back('{dst_addr, dst_data});
        if (busy) busy_cyc++;
        if (!proc_en) pen_low++;
        if (load_rom) loads++;
        if (load_rom && dst_write) excl_viol++;
    end

    logic [22:0] exp_src = '0;
    logic [15:0] exp_dst = '0;

    task automatic prog(input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        en = 1'b1; write = 1'b1; wr_mode = m; ctrl_data = d;
        @(negedge clk);
        en = 1'b0; write = 1'b0;
    endtask

    // Wait for busy to drop; optionally fire register writes while busy.
    task automatic wait_idle(input int budget, input bit poke, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            en = 1'b0; write = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (poke && $urandom_range(3, 0) == 0) begin
                en = 1'b1; write = 1'b1;
                wr_mode = 2'($urandom); ctrl_data = 16'($urandom);
            end
        end
        en = 1'b0; write = 1'b0;
    endtask

    task automatic copy(input logic [22:0] s, input logic [15:0] d, input int n,
                        input bit reprog, input bit rand_lat, input bit poke);
        int exp_busy;
        int l;
        bit ok;
        exp_busy = 0;
        wq.delete();
        lat_q.delete();
        for (int i = 0; i < n; i++) begin
            l = rand_lat ? int'($urandom_range(20, 1)) : 1;
            lat_q.push_back(l);
            exp_busy += 2 + l;
        end
        if (reprog) begin
            prog(2'd0, s[15:0]);
            prog(2'd1, {9'd0, s[22:16]});
            prog(2'd2, d);
            exp_src = s;
            exp_dst = d;
        end
        busy_cyc = 0;
        pen_low  = 0;
        prog(2'd3, 16'(n));
        wait_idle(5000, poke, ok);
        check("copy_done", 32'(ok), 32'd1);
        check("write_count", 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check("wr_addr", 32'(wq[i].a), 32'(16'(exp_dst + 16'(i))));
            check("wr_data", 32'(wq[i].d), 32'(rom_word(23'(exp_src + 23'(i)))));
        end
        check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
        check("proc_en_low_cycles", 32'(pen_low), 32'(exp_busy));
        check("err_clear", 32'(err), 32'd0);
        check("proc_en_after", 32'(proc_en), 32'd1);
        exp_src = 23'(exp_src + 23'(n));
        exp_dst = 16'(exp_dst + 16'(n));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_proc_en"}, 32'(proc_en), 32'd1);
        check({tag, "_load_rom"}, 32'(load_rom), 32'd0);
        check({tag, "_dst_write"}, 32'(dst_write), 32'd0);
        check({tag, "_src_addr"}, 32'(src_addr), 32'd0);
        check({tag, "_dst_addr"}, 32'(dst_addr), 32'd0);
        check({tag, "_dst_data"}, 32'(dst_data), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bit ok;
        int seen;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed copy, one-cycle ROM latency.
        copy(23'h012345, 16'h4000, 3, 1'b1, 1'b0, 1'b0);

        // Zero length must not start anything.
        loads = 0;
        prog(2'd3, 16'd0);
        repeat (5) @(negedge clk);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_proc_en", 32'(proc_en), 32'd1);
        check("len0_loads", 32'(loads), 32'd0);

        // Timeout with ready withheld.
        withhold = 1'b1;
        wq.delete();
        busy_cyc = 0;
        prog(2'd3, 16'd2);
        wait_idle(600, 1'b0, ok);
        check("tmo_done", 32'(ok), 32'd1);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_writes", 32'(wq.size()), 32'd0);
        check("tmo_busy_cycles", 32'(busy_cyc), 32'd256);
        check("tmo_proc_en", 32'(proc_en), 32'd1);
        withhold = 1'b0;
        // Restart without reprogramming: addresses untouched by the abort, err cleared.
        copy(exp_src, exp_dst, 2, 1'b0, 1'b0, 1'b0);

        // Address wrap-around on both sides.
        copy(23'h7FFFFF, 16'hFFFF, 2, 1'b1, 1'b0, 1'b0);

        // Chained copy continuing from post-increment addresses.
        copy(exp_src, exp_dst, 3, 1'b0, 1'b1, 1'b0);

        // Reset during WAIT of word 2 of 4.
        prog(2'd0, 16'h1000);
        prog(2'd1, 16'd0);
        prog(2'd2, 16'h2000);
        wq.delete();
        lat_q.delete();
        for (int i = 0; i < 4; i++) lat_q.push_back(3);
        prog(2'd3, 16'd4);
        seen = load_rom ? 1 : 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clk);
            if (load_rom) seen++;
        end
        check("rst_mid_reached", 32'(seen), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_writes", 32'(wq.size()), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_src = '0;
        exp_dst = '0;

        // Randomized copies with stray ready pulses and register writes while busy.
        noise = 1'b1;
        for (int k = 0; k < 10; k++) begin
            copy(23'($urandom), 16'($urandom), int'($urandom_range(6, 1)),
                 (k % 3) != 1, 1'b1, 1'b1);
        end
        noise = 1'b0;

        check("load_write_exclusive", 32'(excl_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
